// File: rtl/ticket_cnt_arbiter.sv
// Round-robin arbiter handing out tickets from one persistent counter.
// Optional macro CNT_SAT_EN: counter saturates at all-ones instead of wrapping.
module ticket_cnt_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int INIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] ack_i,
    input  logic         clr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] ticket_o,
    output logic         busy_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] win, win_nxt;
    logic [PW-1:0] pick;
    logic [N-1:0]  gnt, gnt_nxt;
    logic [W-1:0]  ticket, ticket_nxt;

    // First set request at or above ptr, wrapping past N-1 back to 0.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

`ifdef CNT_SAT_EN
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
`else
    assign cnt_inc = cnt + 1'b1;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ptr_nxt    = ptr;
        win_nxt    = win;
        gnt_nxt    = gnt;
        ticket_nxt = ticket;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    state_nxt  = GRANT;
                    win_nxt    = pick;
                    gnt_nxt    = N'(1) << pick;
                    ticket_nxt = cnt;
                end
            end
            GRANT: begin
                // Only the holder's ack releases; a dropped req does nothing.
                if (ack_i[win]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = cnt_inc;
                    ptr_nxt   = (win == PW'(N - 1)) ? '0 : win + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Clear beats a coincident release increment.
        if (clr_i) cnt_nxt = W'(INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= W'(INIT);
            ptr    <= '0;
            win    <= '0;
            gnt    <= '0;
            ticket <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            win    <= win_nxt;
            gnt    <= gnt_nxt;
            ticket <= ticket_nxt;
        end
    end

    assign gnt_o    = gnt;
    assign ticket_o = ticket;
    assign busy_o   = (state == GRANT);
endmodule

// File: doc/ticket_cnt_arbiter.md
# ticket_cnt_arbiter

Round-robin arbiter that shares one persistent counter among N requesters and hands each granted requester a unique, monotonically issued ticket value. It is the run-time equivalent of a static counter whose state survives across calls: the counter persists across grants and is never re-initialised per call. It sits between request-generating agents and any shared sequence-numbering resource, such as transaction IDs or tags.

## Interface
- N, 4: number of requesters (2..16).
- W, 8: counter and ticket width in bits.
- INIT, 1: counter value after reset and after clear. Must fit in W bits.
- clk  input  1  sole clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  input  N  per-requester request level. Held high until acknowledged.
- ack_i  input  N  per-requester acknowledge. Only the bit of the currently granted requester is honoured.
- clr_i  input  1  synchronous clear of the counter to INIT.
- gnt_o  output  N  one-hot grant, held through the GRANT state.
- ticket_o  output  W  ticket value for the granted requester. Valid while gnt_o is nonzero.
- busy_o  output  1  high in the GRANT state.

## Operation
- Two-state FSM:
  - IDLE: if any req_i bit is high, pick the winner, go to GRANT, and register gnt_o = onehot(winner) and ticket_o = cnt.
  - GRANT: hold gnt_o and ticket_o stable. When ack_i[winner] is high, return to IDLE, clear gnt_o, increment cnt, and set ptr = winner+1 mod N.
- Round-robin arbitration: search from ptr upward with wrap; the first set req_i bit wins. ptr resets to 0.
- A requester dropping req_i while granted has no effect. Only ack releases the grant.
- ack_i bits of non-granted requesters are ignored. ack_i in IDLE is ignored.
- Counter arithmetic: cnt + 1 modulo 2^W. Behaviour when CNT_SAT_EN is defined is given under Configuration.
- clr_i:
  - Sets cnt = INIT at the next edge, in any state.
  - If clr_i coincides with the releasing ack, clear wins and cnt = INIT, not INIT+1.
  - clr_i does not alter gnt_o, ticket_o, or the FSM state.
  - A ticket already presented stays unchanged until its ack.
- Reset values (asynchronous, as soon as rst_n falls):
  - FSM = IDLE, gnt_o = 0, ticket_o = 0, busy_o = 0, cnt = INIT, ptr = 0.
  - Reset during GRANT aborts the grant with no increment.
- Uniqueness: between clears, and as long as no more than 2^W tickets are issued, no two grants carry the same ticket_o.

## Timing
- Request to grant: req_i high in IDLE at edge k gives gnt_o and ticket_o at edge k+1.
- Ack to release: ack_i high at edge m gives gnt_o = 0 and the new cnt at edge m+1.
- Earliest next grant is edge m+2. Maximum throughput is one ticket per 2 cycles (no ack-in-same-cycle bypass).
- ticket_o holds its last value in IDLE, but it is don't-care whenever gnt_o == 0.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- CNT_SAT_EN
  - Defined: cnt saturates at 2^W-1. Further acks leave it at 2^W-1, so subsequent tickets repeat that value until clr_i.
  - Undefined: cnt wraps from 2^W-1 to 0.

## Test plan
- Reset and single request, N=4, W=8, INIT=1:
  - Reset, then req_i=0001 with ack one cycle after grant.
  - Require gnt_o=0001 and ticket_o=1, then a second request gives ticket_o=2.
- All requesting:
  - req_i=1111 held, each grant acked after 1 cycle.
  - Require grant order 0,1,2,3,0 with tickets 1,2,3,4,5.
- Stray ack and dropped request:
  - Grant requester 2, then assert ack_i=0001 for 3 cycles and drop req_i[2].
  - Require gnt_o to stay 0100 with ticket unchanged until ack_i[2].
- Clear collision:
  - With cnt=7, assert clr_i in the same cycle as the releasing ack.
  - Require the next ticket to be 1 (INIT).
- Wrap versus saturate, W=4:
  - Issue 17 tickets from INIT=1.
  - Without CNT_SAT_EN: ticket sequence 1..15, 0, 1.
  - With CNT_SAT_EN: ticket sequence 1..15, 15, 15.
- Reset mid-grant:
  - Drop rst_n while gnt_o=0010 with ticket 5.
  - Require gnt_o=0 immediately (asynchronously), and after release the first ticket is 1 with grant to requester 0 if it is requesting.
